// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider.
// Holds the default counter width, the channel limit, the per-channel
// reset divisors and the channel operating-mode encoding.
package clkdiv_pkg;

   // Default width of the half-period counter and divisor registers.
   localparam int CNT_W_DEF = 20;

   // Largest channel count the 4-bit write address can reach.
   localparam int MAX_CH = 16;

   // Half-period loaded into H and S of each channel at reset.
   // Channel 1 runs twice as fast as the others out of reset.
   localparam int DEF_HALF [MAX_CH] = '{
      500000, 250000, 500000, 500000,
      500000, 500000, 500000, 500000,
      500000, 500000, 500000, 500000,
      500000, 500000, 500000, 500000
   };

   // Operating mode of one channel for the current cycle, in priority order.
   typedef enum logic [1:0] {
      CH_SYNC = 2'd0,   // global restart
      CH_STOP = 2'd1,   // enable low: everything frozen
      CH_IDLE = 2'd2,   // enabled but H == 0: output parked low
      CH_RUN  = 2'd3    // counting
   } ch_mode_e;

   // Reset divisor for a channel index.
   function automatic int def_half(input int ch);
      return DEF_HALF[ch];
   endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: active half-period H, shadow S, pend flag,
// half-period counter, registered square wave and rising-edge tick.
// New divisors are staged in S and only take effect at a half-period
// boundary (wrap), at a sync, or immediately while H is zero.
module clkdiv_ch
   import clkdiv_pkg::*;
#(
   parameter int              CNT_W    = CNT_W_DEF,
   parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF[0])
)(
   input  logic             mclk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_half,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   ch_mode_e         mode;
   logic             wrap;

   // Classify the cycle: sync beats enable, enable beats the H==0 park.
   always_comb begin
      mode = CH_RUN;
      if (sync) begin
         mode = CH_SYNC;
      end else if (!en) begin
         mode = CH_STOP;
      end else if (half_q == '0) begin
         mode = CH_IDLE;
      end
      wrap = (mode == CH_RUN) && (cnt_q == half_q - ONE);
   end

   // Next-state logic for counter, output phase and divisor staging.
   always_comb begin
      half_d   = half_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      case (mode)
         CH_SYNC: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (wr) begin
               // A write alongside sync bypasses the shadow stage.
               half_d   = wr_half;
               shadow_d = wr_half;
               pend_d   = 1'b0;
            end else if (pend_q) begin
               half_d = shadow_q;
               pend_d = 1'b0;
            end
         end
         CH_STOP: begin
            if (wr) begin
               shadow_d = wr_half;
               pend_d   = 1'b1;
            end
         end
         CH_IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pend_q) begin
               half_d = shadow_q;
               pend_d = 1'b0;
            end
            if (wr) begin
               shadow_d = wr_half;
               pend_d   = 1'b1;
            end
         end
         CH_RUN: begin
            if (wrap) begin
               cnt_d  = '0;
               clk_d  = ~clk_q;
               tick_d = ~clk_q;
               if (wr) begin
                  // Write landing on the boundary applies at this boundary.
                  half_d   = wr_half;
                  shadow_d = wr_half;
                  pend_d   = 1'b0;
               end else if (pend_q) begin
                  half_d = shadow_q;
                  pend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + ONE;
               if (wr) begin
                  shadow_d = wr_half;
                  pend_d   = 1'b1;
               end
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   // State register with synchronous active-low reset to the channel default.
   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         half_q   <= RST_HALF;
         shadow_q <= RST_HALF;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         clk_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         half_q   <= half_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         clk_q    <= clk_d;
         tick_q   <= tick_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;
   assign pend    = pend_q;

endmodule

// File: rtl/clkdiv_prog.sv
// Programmable multi-channel clock divider. Decodes the shared divisor
// write port onto N_CH independent channels, all running from mclk.
// Every output comes straight from a channel flop.
module clkdiv_prog
   import clkdiv_pkg::*;
#(
   parameter int N_CH  = 4,          // 1..MAX_CH
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             mclk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  en,
   input  logic             sync,
   input  logic             wr_en,
   input  logic [3:0]       wr_ch,
   input  logic [CNT_W-1:0] wr_half,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  pend
);

   logic [N_CH-1:0] wr_sel;

   // One-hot write select; indices at or above N_CH match no channel.
   always_comb begin
      wr_sel = '0;
      for (int c = 0; c < N_CH; c++) begin
         wr_sel[c] = wr_en && (wr_ch == 4'(c));
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         clkdiv_ch #(
            .CNT_W    (CNT_W),
            .RST_HALF (CNT_W'(def_half(gi)))
         ) u_ch (
            .mclk    (mclk),
            .rst_n   (rst_n),
            .en      (en[gi]),
            .sync    (sync),
            .wr      (wr_sel[gi]),
            .wr_half (wr_half),
            .clk_out (clk_out[gi]),
            .tick    (tick[gi]),
            .pend    (pend[gi])
         );
      end
   endgenerate

endmodule
